mem8_boot_arb: RTL and testbench

//  Owns the single-port byte memory (spram8_128k via mb8_io) shared by the dictionary loader,
//  a debug host and the eJsv32k core. Sequences boot: hold core in reset, stream the dictionary

---
 rtl/mem8_boot_arb.sv | 170 +++++++++++++++++
 tb/tb_mem8_boot_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem8_boot_arb.sv
// Boot sequencer and arbiter for the shared single-port byte memory: loads the dictionary,
// verifies it by checksum, then hands the memory to the core (or to the debug host while halted).
module mem8_boot_arb #(
   parameter int             ASZ  = 17,
   parameter logic [ASZ-1:0] DICT = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           halt,
   input  logic           resume,
   input  logic           ld_valid,
   input  logic [7:0]     ld_data,
   input  logic           ld_last,
   output logic           ld_ready,
   output logic           core_clr,
   input  logic [31:0]    core_addr,
   input  logic           core_we,
   input  logic [7:0]     core_wdata,
   output logic [7:0]     core_rdata,
   input  logic           dbg_req,
   input  logic           dbg_we,
   input  logic [ASZ-1:0] dbg_addr,
   input  logic [7:0]     dbg_wdata,
   output logic           dbg_ack,
   output logic [7:0]     dbg_rdata,
   output logic [ASZ-1:0] mem_addr,
   output logic           mem_we,
   output logic [7:0]     mem_wdata,
   input  logic [7:0]     mem_rdata,
   output logic [ASZ-1:0] here,
   output logic           err,
   output logic [2:0]     state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_VERIFY = 3'd2,
      S_RUN    = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [ASZ:0]   r_cnt;
   logic [ASZ:0]   r_vcnt;
   logic [7:0]     r_sum;
   logic [7:0]     r_vsum;
   logic [ASZ-1:0] r_here;
   logic           r_err;
   logic           r_core_clr;
   logic           r_dbg_ack;

   logic           w_ld_acc;
   logic           w_ld_ovf;
   logic [ASZ-1:0] w_ld_addr;
   logic [ASZ-1:0] w_ver_addr;
   logic           w_ver_done;
   logic [7:0]     w_vsum_nxt;
   logic           w_dbg_go;
   logic           w_restart;
   logic           w_unused;

   assign w_unused   = ^core_addr[31:ASZ];

   assign w_ld_acc   = (r_state == S_LOAD) && ld_valid;
   assign w_ld_addr  = DICT + r_cnt[ASZ-1:0];
   assign w_ld_ovf   = w_ld_acc && !ld_last && (w_ld_addr == '1);
   assign w_ver_addr = DICT + r_vcnt[ASZ-1:0];
   assign w_ver_done = (r_state == S_VERIFY) && (r_vcnt == r_cnt);
   assign w_vsum_nxt = r_vsum + mem_rdata;
   assign w_dbg_go   = (r_state == S_HALT) && dbg_req && !start;
   assign w_restart  = ((r_state == S_IDLE) || (r_state == S_HALT)) && start;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = S_LOAD;
         S_LOAD: begin
            if (w_ld_acc && ld_last) w_next = S_VERIFY;
            else if (w_ld_ovf)       w_next = S_HALT;
         end
         S_VERIFY: if (w_ver_done) w_next = (w_vsum_nxt == r_sum) ? S_RUN : S_HALT;
         S_RUN:  if (halt) w_next = S_HALT;
         S_HALT: begin
            if (start)                w_next = S_LOAD;
            else if (resume && !r_err) w_next = S_RUN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Memory port mux: owner is chosen purely by current state, so the cycle's access
   // (including one coinciding with rst or halt) is always issued.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = 8'h00;
      case (r_state)
         S_LOAD: begin
            mem_addr  = w_ld_addr;
            mem_we    = ld_valid;
            mem_wdata = ld_data;
         end
         S_VERIFY: mem_addr = w_ver_addr;
         S_RUN: begin
            mem_addr  = core_addr[ASZ-1:0];
            mem_we    = core_we;
            mem_wdata = core_wdata;
         end
         S_HALT: begin
            if (w_dbg_go) begin
               mem_addr  = dbg_addr;
               mem_we    = dbg_we;
               mem_wdata = dbg_wdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_core_clr <= 1'b1;
         r_dbg_ack  <= 1'b0;
         r_here     <= DICT;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_vcnt     <= '0;
      end else begin
         r_state    <= w_next;
         r_core_clr <= (w_next != S_RUN);
         r_dbg_ack  <= w_dbg_go;
         if (w_restart) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end
         if (w_ld_acc) begin
            r_cnt  <= r_cnt + (ASZ+1)'(1);
            r_vcnt <= '0;
            if (ld_last) r_here <= w_ld_addr + ASZ'(1);
            else if (w_ld_ovf) r_err <= 1'b1;
         end
         if (r_state == S_VERIFY) begin
            r_vcnt <= r_vcnt + (ASZ+1)'(1);
            if (w_ver_done && (w_vsum_nxt != r_sum)) r_err <= 1'b1;
         end
      end
   end

   // Checksum datapath; byte for verify address k arrives one cycle later, hence the skip at vcnt 0.
   always_ff @(posedge clk) begin
      if (w_restart) r_sum <= 8'h00;
      else if (w_ld_acc) r_sum <= r_sum + ld_data;
      if (w_ld_acc) r_vsum <= 8'h00;
      else if ((r_state == S_VERIFY) && (r_vcnt != '0)) r_vsum <= w_vsum_nxt;
   end

   assign ld_ready   = (r_state == S_LOAD);
   assign core_clr   = r_core_clr;
   assign core_rdata = mem_rdata;
   assign dbg_ack    = r_dbg_ack;
   assign dbg_rdata  = r_dbg_ack ? mem_rdata : 8'h00;
   assign here       = r_here;
   assign err        = r_err;
   assign state_o    = r_state;

endmodule

// File: tb/tb_mem8_boot_arb.sv
// Directed bench for mem8_boot_arb: one instance at DICT=0 with a memory model, one at
// DICT='h1FFFE for the address overflow case.
module tb_mem8_boot_arb;
   localparam int ASZ = 17;

   logic           clk;
   logic           rst, start, halt, resume;
   logic           ld_valid, ld_last;
   logic [7:0]     ld_data;
   logic [31:0]    core_addr;
   logic           core_we;
   logic [7:0]     core_wdata;
   logic           dbg_req, dbg_we;
   logic [ASZ-1:0] dbg_addr;
   logic [7:0]     dbg_wdata;

   logic           ld_ready0, core_clr0, dbg_ack0, mem_we0, err0;
   logic [7:0]     core_rdata0, dbg_rdata0, mem_wdata0, mem_rdata0;
   logic [ASZ-1:0] mem_addr0, here0;
   logic [2:0]     state0;

   logic           ld_ready5, core_clr5, dbg_ack5, mem_we5, err5;
   logic [7:0]     core_rdata5, dbg_rdata5, mem_wdata5, mem_rdata5;
   logic [ASZ-1:0] mem_addr5, here5;
   logic [2:0]     state5;

   logic           bd_en;
   logic [ASZ-1:0] bd_addr;
   logic [7:0]     bd_data;

   logic [7:0]     mem0 [0:(1<<ASZ)-1];
   logic [ASZ-1:0] wlog0 [0:1023];
   int             wcnt0 = 0;
   int             wcnt5 = 0;
   int             nvec  = 0;
   int             nerr  = 0;
   int             w0, w5;

   logic [7:0] b1 [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic       v2 [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [7:0] d2 [0:4] = '{8'hA1, 8'h00, 8'h00, 8'hA2, 8'hA3};

   mem8_boot_arb #(.ASZ(ASZ), .DICT(17'h00000)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .resume(resume),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready0),
      .core_clr(core_clr0), .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata),
      .core_rdata(core_rdata0), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack0), .dbg_rdata(dbg_rdata0),
      .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
      .here(here0), .err(err0), .state_o(state0)
   );

   mem8_boot_arb #(.ASZ(ASZ), .DICT(17'h1FFFE)) u_dut5 (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .resume(resume),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready5),
      .core_clr(core_clr5), .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata),
      .core_rdata(core_rdata5), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack5), .dbg_rdata(dbg_rdata5),
      .mem_addr(mem_addr5), .mem_we(mem_we5), .mem_wdata(mem_wdata5), .mem_rdata(mem_rdata5),
      .here(here5), .err(err5), .state_o(state5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory with registered read and a backdoor for corruption
   always @(posedge clk) begin
      if (bd_en) mem0[bd_addr] <= bd_data;
      if (mem_we0) begin
         mem0[mem_addr0]      <= mem_wdata0;
         wlog0[wcnt0 % 1024] <= mem_addr0;
         wcnt0                <= wcnt0 + 1;
      end
      mem_rdata0 <= mem0[mem_addr0];
   end

   always @(posedge clk) begin
      mem_rdata5 <= 8'h00;
      if (mem_we5) wcnt5 <= wcnt5 + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
   endtask

   initial begin
      rst = 1'b1; start = 0; halt = 0; resume = 0;
      ld_valid = 0; ld_last = 0; ld_data = 0;
      core_addr = 0; core_we = 0; core_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      bd_en = 0; bd_addr = 0; bd_data = 0;
      tick(); tick();

      chk("rst_state", state0, 0);
      chk("rst_clr", core_clr0, 1);
      chk("rst_ldrdy", ld_ready0, 0);
      chk("rst_ack", dbg_ack0, 0);
      chk("rst_rdata", dbg_rdata0, 0);
      chk("rst_here", here0, 0);
      chk("rst_err", err0, 0);
      chk("rst_we", mem_we0, 0);
      chk("rst_here5", here5, 17'h1FFFE);
      rst = 1'b0;

      // 1: four-byte load, verify, run
      start = 1; tick(); start = 0;
      chk("t1_load", state0, 1);
      chk("t1_ldrdy", ld_ready0, 1);
      w0 = wcnt0;
      for (int i = 0; i < 4; i++) begin
         put(b1[i], i == 3);
         #1;
         chk("t1_we", mem_we0, 1);
         chk("t1_addr", mem_addr0, i);
         tick();
      end
      ld_valid = 0; ld_last = 0;
      chk("t1_verify", state0, 2);
      chk("t1_nwr", wcnt0 - w0, 4);
      chk("t1_ldrdy_v", ld_ready0, 0);
      repeat (4) tick();
      chk("t1_verify_end", state0, 2);
      chk("t1_clr_v", core_clr0, 1);
      tick();
      chk("t1_run", state0, 3);
      chk("t1_clr", core_clr0, 0);
      chk("t1_here", here0, 4);
      chk("t1_err", err0, 0);
      core_addr = 32'h2;
      tick();
      chk("t1_crdata", core_rdata0, 8'h33);

      // 2: loader gaps
      halt = 1; tick(); halt = 0;
      chk("t2_halt", state0, 4);
      chk("t2_clr", core_clr0, 1);
      start = 1; tick(); start = 0;
      chk("t2_load", state0, 1);
      w0 = wcnt0;
      for (int i = 0; i < 5; i++) begin
         ld_valid = v2[i]; ld_data = d2[i]; ld_last = (i == 4);
         tick();
         if (i == 2) chk("t2_gap_state", state0, 1);
      end
      ld_valid = 0; ld_last = 0;
      chk("t2_nwr", wcnt0 - w0, 3);
      chk("t2_a0", wlog0[w0 % 1024], 0);
      chk("t2_a1", wlog0[(w0 + 1) % 1024], 1);
      chk("t2_a2", wlog0[(w0 + 2) % 1024], 2);
      chk("t2_here", here0, 3);
      chk("t2_verify", state0, 2);
      repeat (4) tick();
      chk("t2_run", state0, 3);

      // 3: corruption during verify
      halt = 1; tick(); halt = 0;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 4; i++) begin
         put(b1[i], i == 3);
         tick();
      end
      ld_valid = 0; ld_last = 0;
      chk("t3_verify", state0, 2);
      bd_en = 1; bd_addr = 17'h1; bd_data = 8'hFF;
      tick();
      bd_en = 0;
      repeat (3) tick();
      chk("t3_still_verify", state0, 2);
      tick();
      chk("t3_halt", state0, 4);
      chk("t3_err", err0, 1);
      chk("t3_clr", core_clr0, 1);
      resume = 1; tick(); resume = 0;
      chk("t3_resume_ign", state0, 4);
      chk("t3_clr2", core_clr0, 1);

      // 4: halt, debug write/read, resume
      start = 1; tick(); start = 0;
      chk("t4_load", state0, 1);
      chk("t4_errclr", err0, 0);
      put(8'h5C, 1'b1); tick();
      ld_valid = 0; ld_last = 0;
      chk("t4_here", here0, 1);
      tick();
      chk("t4_verify", state0, 2);
      tick();
      chk("t4_run", state0, 3);
      core_addr = 32'h200; core_we = 1; core_wdata = 8'h77; halt = 1;
      #1;
      chk("t4_cwe_halt", mem_we0, 1);
      tick();
      halt = 0;
      chk("t4_halt", state0, 4);
      chk("t4_clr", core_clr0, 1);
      #1;
      chk("t4_cwe_mask", mem_we0, 0);
      core_we = 0;
      dbg_req = 1; dbg_we = 1; dbg_addr = 17'h100; dbg_wdata = 8'h5A;
      #1;
      chk("t4_dwe", mem_we0, 1);
      chk("t4_daddr", mem_addr0, 17'h100);
      tick();
      chk("t4_ack_w", dbg_ack0, 1);
      dbg_we = 0;
      tick();
      chk("t4_ack_r", dbg_ack0, 1);
      chk("t4_rd100", dbg_rdata0, 8'h5A);
      dbg_addr = 17'h200;
      tick();
      chk("t4_rd200", dbg_rdata0, 8'h77);
      dbg_req = 0;
      tick();
      chk("t4_ack_off", dbg_ack0, 0);
      resume = 1; tick(); resume = 0;
      chk("t4_resume", state0, 3);
      chk("t4_clr_run", core_clr0, 0);
      dbg_req = 1; tick(); dbg_req = 0;
      chk("t4_dbg_run", dbg_ack0, 0);

      // 6: reset mid-load, then reload
      halt = 1; tick(); halt = 0;
      start = 1; tick(); start = 0;
      put(8'h10, 1'b0); tick();
      put(8'h20, 1'b0); tick();
      put(8'h30, 1'b0); rst = 1;
      #1;
      chk("t6_inflight", mem_we0, 1);
      chk("t6_inaddr", mem_addr0, 2);
      tick();
      rst = 0; ld_valid = 0;
      chk("t6_idle", state0, 0);
      chk("t6_here", here0, 0);
      chk("t6_ldrdy", ld_ready0, 0);
      chk("t6_clr", core_clr0, 1);
      start = 1; tick(); start = 0;
      put(8'h10, 1'b0); tick();
      put(8'h20, 1'b1); tick();
      ld_valid = 0; ld_last = 0;
      chk("t6_here2", here0, 2);
      repeat (3) tick();
      chk("t6_run", state0, 3);
      chk("t6_err", err0, 0);

      // 5: overflow at top of memory
      rst = 1; tick(); rst = 0;
      chk("t5_idle", state5, 0);
      start = 1; tick(); start = 0;
      w5 = wcnt5;
      put(8'hAA, 1'b0);
      #1;
      chk("t5_a0", mem_addr5, 17'h1FFFE);
      tick();
      chk("t5_load", state5, 1);
      put(8'hBB, 1'b0);
      #1;
      chk("t5_a1", mem_addr5, 17'h1FFFF);
      chk("t5_we1", mem_we5, 1);
      tick();
      chk("t5_halt", state5, 4);
      chk("t5_err", err5, 1);
      chk("t5_clr", core_clr5, 1);
      put(8'hCC, 1'b1);
      #1;
      chk("t5_ldrdy", ld_ready5, 0);
      chk("t5_we2", mem_we5, 0);
      tick();
      ld_valid = 0; ld_last = 0;
      chk("t5_nwr", wcnt5 - w5, 2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
